// File: rtl/compuerta_reduccion_serial.sv
// rtl/compuerta_reduccion_serial.sv - serial width-generic reduction gate (AND/OR/XOR/NAND/NOR/XNOR)
//
// Purpose:
//   Reduces an ANCHO-bit operand to a single bit, consuming BITS_POR_CICLO
//   bits per clock (LSB chunk first) under an Inicio/Listo handshake.
//   With TERMINACION_TEMPRANA=1, AND/NAND stop on the first chunk holding a 0
//   and OR/NOR stop on the first chunk holding a 1.
//
// Ports:
//   Reloj      in   clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Inicio     in   start request, sampled only in REPOSO
//   Operacion  in   [2:0] 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 11x invalid
//   Entrada    in   [ANCHO-1:0] operand, captured on the accepted start
//   Ocupado    out  high in OCUPADO and FIN
//   Listo      out  one-cycle pulse marking a fresh Salida/Error
//   Salida     out  result, held until the next Listo
//   Error      out  invalid-operation flag, held like Salida

module compuerta_reduccion_serial #(
    parameter int ANCHO                = 8,
    parameter int BITS_POR_CICLO       = 2,
    parameter bit TERMINACION_TEMPRANA = 1'b0
) (
    input  logic             Reloj,
    input  logic             Reset,
    input  logic             Inicio,
    input  logic [2:0]       Operacion,
    input  logic [ANCHO-1:0] Entrada,
    output logic             Ocupado,
    output logic             Listo,
    output logic             Salida,
    output logic             Error
);

    localparam int PASOS = ANCHO / BITS_POR_CICLO;
    // Counter keeps at least one bit so PASOS=1 still elaborates cleanly.
    localparam int CW    = (PASOS > 1) ? $clog2(PASOS) : 1;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        OCUPADO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_t;

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic [ANCHO-1:0]       r_desp;
    logic [2:0]             r_op;
    logic                   r_acum;
    logic [CW-1:0]          r_cont;
    logic                   r_salida;
    logic                   r_error;

    logic [BITS_POR_CICLO-1:0] w_trozo;
    logic                   w_trozo_and;
    logic                   w_trozo_or;
    logic                   w_trozo_xor;
    logic                   w_op_valida;
    logic                   w_invertir;
    base_t                  w_base;
    logic                   w_acum_sig;
    logic                   w_ultimo;
    logic                   w_temprana;
    logic                   w_fin;
    logic                   w_identidad;

    // Chunk currently at the bottom of the shift register.
    assign w_trozo     = r_desp[BITS_POR_CICLO-1:0];
    assign w_trozo_and = &w_trozo;
    assign w_trozo_or  = |w_trozo;
    assign w_trozo_xor = ^w_trozo;

    assign w_op_valida = (r_op[2:1] != 2'b11);

    // NAND/NOR/XNOR share the datapath of AND/OR/XOR and invert at the end.
    always_comb begin
        w_base     = BASE_AND;
        w_invertir = 1'b0;
        case (r_op)
            3'b000:  begin w_base = BASE_AND; w_invertir = 1'b0; end
            3'b001:  begin w_base = BASE_OR;  w_invertir = 1'b0; end
            3'b010:  begin w_base = BASE_XOR; w_invertir = 1'b0; end
            3'b011:  begin w_base = BASE_AND; w_invertir = 1'b1; end
            3'b100:  begin w_base = BASE_OR;  w_invertir = 1'b1; end
            3'b101:  begin w_base = BASE_XOR; w_invertir = 1'b1; end
            default: begin w_base = BASE_AND; w_invertir = 1'b0; end
        endcase
    end

    always_comb begin
        w_acum_sig = r_acum;
        case (w_base)
            BASE_AND: w_acum_sig = r_acum & w_trozo_and;
            BASE_OR:  w_acum_sig = r_acum | w_trozo_or;
            BASE_XOR: w_acum_sig = r_acum ^ w_trozo_xor;
            default:  w_acum_sig = r_acum;
        endcase
    end

    // Identity of the incoming operation: 1 for AND/NAND, 0 otherwise.
    assign w_identidad = (Operacion == 3'b000) || (Operacion == 3'b011);

    assign w_ultimo = (r_cont == CW'(PASOS - 1));

    // Early stop fires once the accumulated value can no longer change.
    // Invalid ops never stop early so they always run the full PASOS cycles.
    assign w_temprana = TERMINACION_TEMPRANA && w_op_valida &&
                        (((w_base == BASE_AND) && !w_trozo_and) ||
                         ((w_base == BASE_OR)  &&  w_trozo_or));

    assign w_fin = w_ultimo || w_temprana;

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO:  if (Inicio) w_estado_sig = OCUPADO;
            OCUPADO: if (w_fin)  w_estado_sig = FIN;
            FIN:     w_estado_sig = REPOSO;
            default: w_estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        Ocupado = 1'b0;
        Listo   = 1'b0;
        case (r_estado)
            OCUPADO: Ocupado = 1'b1;
            FIN:     begin Ocupado = 1'b1; Listo = 1'b1; end
            default: begin Ocupado = 1'b0; Listo = 1'b0; end
        endcase
    end

    assign Salida = r_salida;
    assign Error  = r_error;

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            r_estado <= REPOSO;
            r_desp   <= '0;
            r_op     <= '0;
            r_acum   <= 1'b0;
            r_cont   <= '0;
            r_salida <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            case (r_estado)
                REPOSO: begin
                    if (Inicio) begin
                        r_desp <= Entrada;
                        r_op   <= Operacion;
                        r_acum <= w_identidad;
                        r_cont <= '0;
                    end
                end
                OCUPADO: begin
                    r_acum <= w_acum_sig;
                    r_desp <= r_desp >> BITS_POR_CICLO;
                    r_cont <= r_cont + CW'(1);
                    if (w_fin) begin
                        r_salida <= w_op_valida ? (w_acum_sig ^ w_invertir) : 1'b0;
                        r_error  <= !w_op_valida;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compuerta_reduccion_serial.sv
// tb/tb_compuerta_reduccion_serial.sv - self-checking bench for compuerta_reduccion_serial

module tb_compuerta_reduccion_serial;

    localparam int ANCHO = 8;
    localparam int BPC   = 2;
    localparam int PASOS = ANCHO / BPC;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio;
    logic [2:0] op;
    logic [7:0] ent;
    logic [1:0] ocup, listo, sal, err;

    always #5 clk = ~clk;

    // Instance 0 runs full length, instance 1 has early termination enabled.
    compuerta_reduccion_serial #(.ANCHO(ANCHO), .BITS_POR_CICLO(BPC), .TERMINACION_TEMPRANA(1'b0)) u_dut0 (
        .Reloj(clk), .Reset(rst), .Inicio(inicio), .Operacion(op), .Entrada(ent),
        .Ocupado(ocup[0]), .Listo(listo[0]), .Salida(sal[0]), .Error(err[0])
    );

    compuerta_reduccion_serial #(.ANCHO(ANCHO), .BITS_POR_CICLO(BPC), .TERMINACION_TEMPRANA(1'b1)) u_dut1 (
        .Reloj(clk), .Reset(rst), .Inicio(inicio), .Operacion(op), .Entrada(ent),
        .Ocupado(ocup[1]), .Listo(listo[1]), .Salida(sal[1]), .Error(err[1])
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result and cycle count from whole-operand reductions.
    function automatic void modelo(input logic [7:0] e, input logic [2:0] o, input bit tt,
                                   output int pasos, output logic r, output logic er);
        int base;
        int trozo;
        bit hallado;
        pasos   = PASOS;
        er      = (o >= 3'd6);
        base    = int'(o) % 3;
        hallado = 1'b0;
        if (er) begin
            r = 1'b0;
        end else begin
            if (base == 0)      r = &e;
            else if (base == 1) r = |e;
            else                r = ^e;
            if (o >= 3'd3) r = ~r;
            if (tt && base != 2) begin
                for (int k = 0; k < PASOS; k++) begin
                    trozo = (int'(e) >> (k * BPC)) & ((1 << BPC) - 1);
                    if (!hallado && ((base == 0 && trozo != (1 << BPC) - 1) || (base == 1 && trozo != 0))) begin
                        hallado = 1'b1;
                        pasos   = k + 1;
                    end
                end
            end
        end
    endfunction

    bit   m_busy [2];
    int   m_rem  [2];
    bit   m_listo[2];
    logic m_sal  [2];
    logic m_err  [2];
    logic m_pres [2];
    logic m_perr [2];

    always @(posedge clk) begin
        int   st;
        logic r, er;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d]  <= 1'b0;
                m_rem[d]   <= 0;
                m_listo[d] <= 1'b0;
                m_sal[d]   <= 1'b0;
                m_err[d]   <= 1'b0;
            end else if (m_listo[d]) begin
                m_listo[d] <= 1'b0;
                m_busy[d]  <= 1'b0;
            end else if (m_busy[d]) begin
                if (m_rem[d] == 1) begin
                    m_listo[d] <= 1'b1;
                    m_sal[d]   <= m_pres[d];
                    m_err[d]   <= m_perr[d];
                end
                m_rem[d] <= m_rem[d] - 1;
            end else if (inicio) begin
                modelo(ent, op, d == 1, st, r, er);
                m_busy[d] <= 1'b1;
                m_rem[d]  <= st;
                m_pres[d] <= r;
                m_perr[d] <= er;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ocupado%0d", d), 32'(ocup[d]),  32'(m_busy[d]));
                chk($sformatf("listo%0d", d),   32'(listo[d]), 32'(m_listo[d]));
                chk($sformatf("salida%0d", d),  32'(sal[d]),   32'(m_sal[d]));
                chk($sformatf("error%0d", d),   32'(err[d]),   32'(m_err[d]));
            end
        end
    end

    task automatic run_op(input logic [7:0] e, input logic [2:0] o, input logic exp_s, input logic exp_e,
                          input int l0, input int l1, input bit inject, input string tag);
        int lat;
        bit seen[2];
        int lexp[2];
        lexp[0] = l0;
        lexp[1] = l1;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        ent = e;
        op = o;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        lat = 0;
        while (!(seen[0] && seen[1]) && lat < 20) begin
            @(negedge clk);
            lat++;
            for (int d = 0; d < 2; d++) begin
                if (!seen[d] && listo[d]) begin
                    seen[d] = 1'b1;
                    chk($sformatf("%s_lat%0d", tag, d), 32'(lat), 32'(lexp[d]));
                    chk($sformatf("%s_sal%0d", tag, d), 32'(sal[d]), 32'(exp_s));
                    chk($sformatf("%s_err%0d", tag, d), 32'(err[d]), 32'(exp_e));
                end
            end
            if (inject) begin
                inicio = (lat == 2);
                if (lat == 2) begin
                    ent = ~e;
                    op  = 3'b001;
                end
            end
        end
        inicio = 1'b0;
        for (int d = 0; d < 2; d++)
            if (!seen[d]) chk($sformatf("%s_timeout%0d", tag, d), 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        inicio = 1'b0;
        op = 3'b000;
        ent = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_ocup", 32'(ocup), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_sal", 32'(sal), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);

        run_op(8'hFF, 3'b000, 1'b1, 1'b0, 4, 4, 1'b0, "and_ff");
        run_op(8'hFE, 3'b000, 1'b0, 1'b0, 4, 1, 1'b0, "and_fe");
        run_op(8'h96, 3'b010, 1'b0, 1'b0, 4, 4, 1'b0, "xor_96");
        run_op(8'h97, 3'b101, 1'b0, 1'b0, 4, 4, 1'b0, "xnor_97");
        run_op(8'h00, 3'b100, 1'b1, 1'b0, 4, 4, 1'b0, "nor_00");
        run_op(8'h80, 3'b011, 1'b1, 1'b0, 4, 1, 1'b0, "nand_80");
        run_op(8'hFC, 3'b000, 1'b0, 1'b0, 4, 1, 1'b0, "and_fc");
        run_op(8'h3F, 3'b000, 1'b0, 1'b0, 4, 4, 1'b0, "and_3f");
        run_op(8'hFF, 3'b110, 1'b0, 1'b1, 4, 4, 1'b0, "inval");
        run_op(8'h0F, 3'b001, 1'b1, 1'b0, 4, 1, 1'b0, "or_0f");
        run_op(8'hFF, 3'b000, 1'b1, 1'b0, 4, 4, 1'b1, "ignored");

        ent = 8'hAA;
        op = 3'b001;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ocup", 32'(ocup), 32'd0);
        chk("midrst_listo", 32'(listo), 32'd0);
        chk("midrst_sal", 32'(sal), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        repeat (6) @(negedge clk);
        run_op(8'h01, 3'b010, 1'b1, 1'b0, 4, 4, 1'b0, "after_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
